// File: rtl/riscv_pkg.sv
// Shared writeback definitions: select codes and the queued result entry layout.
package riscv_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  localparam logic [1:0] WB_SEL_MEM = 2'b10;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic is_result_sel(input logic [1:0] sel);
    return (sel == WB_SEL_ALU) || (sel == WB_SEL_MEM);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; occupancy is tracked by a level counter so full/empty
// never depend on pointer comparison. A push while full is accepted only with a pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     push_ok_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok_o);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(push_ok_o) - LW'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left out of reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/result_drain.sv
// Queues tagged writeback results for a valid/ready consumer, flagging dropped
// results with a sticky overflow bit and counting completed handshakes.
module result_drain
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            wb_data,
  input  logic [1:0]             wb_sel,
  input  logic                   wb_flag,
  input  logic                   clr_ovf,
  output logic [31:0]            out_data,
  output logic                   out_src,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       delivered
);

  wb_entry_t        wr_entry, rd_entry;
  logic             push_req, pop, full, empty, push_ok, drop;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] delivered_q, delivered_d;

  assign push_req      = wb_flag && is_result_sel(wb_sel);
  assign wr_entry.src  = (wb_sel == WB_SEL_MEM);
  assign wr_entry.data = wb_data;
  assign pop           = out_valid && out_ready;
  assign drop          = push_req && !push_ok;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_req),
    .pop_i     (pop),
    .wdata_i   (wr_entry),
    .rdata_o   (rd_entry),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok),
    .level_o   (level)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d       = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
    delivered_d = delivered_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q       <= 1'b0;
      delivered_q <= '0;
    end else begin
      ovf_q       <= ovf_d;
      delivered_q <= delivered_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = rd_entry.data;
  assign out_src   = rd_entry.src;
  assign ovf       = ovf_q;
  assign delivered = delivered_q;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_result_drain.sv
// Randomized and directed bench for result_drain against a queue-based reference model.
module tb_result_drain;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      wb_data = '0;
  logic [1:0]       wb_sel = '0;
  logic             wb_flag = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_src;
  logic             out_valid;
  logic             ovf;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] delivered;

  result_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_data   (wb_data),
    .wb_sel    (wb_sel),
    .wb_flag   (wb_flag),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .level     (level),
    .delivered (delivered)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {src, data}, sticky flag, handshake count.
  logic [32:0]      mq[$];
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_deliv = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [32:0] head;
    check({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({tag, ".level"}, 64'(level), 64'(mq.size()));
    check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    check({tag, ".delivered"}, 64'(delivered), 64'(m_deliv));
    if (mq.size() != 0) begin
      head = mq[0];
      check({tag, ".data"}, 64'(out_data), 64'(head[31:0]));
      check({tag, ".src"}, 64'(out_src), 64'(head[32]));
    end
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare at the falling edge.
  task automatic cycle(input logic [31:0] d, input logic [1:0] s, input logic f,
                       input logic r, input logic c, input string tag);
    bit do_pop, do_push;
    wb_data = d; wb_sel = s; wb_flag = f; out_ready = r; clr_ovf = c;
    @(posedge clk);
    do_pop  = r && (mq.size() != 0);
    do_push = f && (s == 2'b01 || s == 2'b10);
    if (do_pop) begin
      void'(mq.pop_front());
      m_deliv = m_deliv + 1'b1;
    end
    if (c) m_ovf = 1'b0;
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back({(s == 2'b10), d});
      else m_ovf = 1'b1;
    end
    @(negedge clk);
    wb_flag = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    compare_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_deliv = '0;
  endtask

  initial begin
    int n;
    logic [1:0] s;
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single push then pop
    cycle(32'hAA, 2'b01, 1'b1, 1'b0, 1'b0, "single_push");
    check("single_push.exact_level", 64'(level), 64'd1);
    cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, "single_pop");
    check("single_pop.exact_delivered", 64'(delivered), 64'd1);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) cycle(32'(i), 2'b10, 1'b1, 1'b0, 1'b0, $sformatf("fill%0d", i));
    check("overflow.exact_ovf", 64'(ovf), 64'd1);
    check("overflow.exact_level", 64'(level), 64'(DEPTH));
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d.exact_data", i), 64'(out_data), 64'(i));
      cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, $sformatf("drain%0d", i));
    end
    check("drain.empty", 64'(out_valid), 64'd0);

    // Clear overflow, then push while full with a simultaneous pop
    cycle(32'h0, 2'b00, 1'b0, 1'b0, 1'b1, "clr_ovf");
    for (int i = 1; i <= 4; i++) cycle(32'(i + 16), 2'b01, 1'b1, 1'b0, 1'b0, "refill");
    cycle(32'h9, 2'b10, 1'b1, 1'b1, 1'b0, "full_push_pop");
    check("full_push_pop.exact_ovf", 64'(ovf), 64'd0);
    check("full_push_pop.exact_level", 64'(level), 64'(DEPTH));
    for (int i = 0; i < 4; i++) cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, "drain_b");

    // Ignored select codes
    cycle(32'h55, 2'b00, 1'b1, 1'b0, 1'b0, "ign00");
    cycle(32'h66, 2'b11, 1'b1, 1'b0, 1'b0, "ign11");
    cycle(32'h77, 2'b00, 1'b1, 1'b0, 1'b0, "ign00b");

    // Backpressure with random ready and a random mix of select codes
    n = 0;
    for (int i = 0; i < 2000 && n < 100; i++) begin
      logic f;
      f = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      cycle(32'h1000 + 32'(n), s, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), "rand");
      if (f) n++;
    end
    for (int i = 0; i < 20 && mq.size() != 0; i++) cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, "rand_drain");
    check("rand.empty_after_drain", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream at level 3
    cycle(32'hE1, 2'b01, 1'b1, 1'b0, 1'b0, "pre_rst");
    cycle(32'hE2, 2'b10, 1'b1, 1'b0, 1'b0, "pre_rst");
    cycle(32'hE3, 2'b01, 1'b1, 1'b0, 1'b0, "pre_rst");
    #2 reset = 1'b1;
    #1;
    check("async_rst.valid", 64'(out_valid), 64'd0);
    check("async_rst.level", 64'(level), 64'd0);
    check("async_rst.delivered", 64'(delivered), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare_all("post_rst");
    cycle(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, "post_rst_idle");
    cycle(32'hBEEF, 2'b10, 1'b1, 1'b0, 1'b0, "post_rst_push");
    check("post_rst_push.exact_data", 64'(out_data), 64'hBEEF);
    cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, "post_rst_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
